// File: rtl/lfsr_seq_ctrl.sv
// Seed-load/shift LFSR sequencer: captures a seed and step count, runs exactly that many
// Fibonacci shifts, then holds the result under a done/ack handshake. Optional: LFSR_ZERO_GUARD_EN.
module lfsr_seq_ctrl #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0] steps_i,
  output logic             busy_o,
  output logic             load_sel_o,
  output logic             shift_en_o,
  output logic [WIDTH-1:0] state_o,
  output logic             done_o,
`ifdef LFSR_ZERO_GUARD_EN
  output logic             seed_fix_o,
`endif
  input  logic             ack_i
);

  // Handshake: done_o is held high with state_o frozen until ack_i is seen high at a
  // clock edge while in DONE; start_i is only honoured in IDLE and ack_i only in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] load_val;
  logic             seed_zero;

  assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign seed_zero = (seed_q == '0);

`ifdef LFSR_ZERO_GUARD_EN
  // An all-zero seed would lock the register at zero forever; substitute 1.
  assign load_val = seed_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_q;
  logic seed_fix_q;
  assign seed_fix_o = seed_fix_q;
`else
  assign load_val = seed_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      lfsr       <= '0;
      seed_q     <= '0;
      cnt        <= '0;
      busy_o     <= 1'b0;
      load_sel_o <= 1'b0;
      shift_en_o <= 1'b0;
      done_o     <= 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
      seed_fix_q <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (start_i) begin
            seed_q     <= seed_i;
            cnt        <= steps_i;
            fsm        <= LOAD;
            busy_o     <= 1'b1;
            load_sel_o <= 1'b1;
            shift_en_o <= 1'b1;
          end
        end
        LOAD: begin
          lfsr       <= load_val;
          load_sel_o <= 1'b0;
          if (cnt == '0) begin
            fsm        <= DONE;
            shift_en_o <= 1'b0;
            done_o     <= 1'b1;
`ifdef LFSR_ZERO_GUARD_EN
            seed_fix_q <= seed_zero;
`endif
          end else begin
            fsm <= RUN;
          end
        end
        RUN: begin
          lfsr <= lfsr_next;
          cnt  <= cnt - 1'b1;
          // Leaving on a count of 1 makes RUN last exactly the captured number of cycles.
          if (cnt == CNT_W'(1)) begin
            fsm        <= DONE;
            shift_en_o <= 1'b0;
            done_o     <= 1'b1;
`ifdef LFSR_ZERO_GUARD_EN
            seed_fix_q <= seed_zero;
`endif
          end
        end
        DONE: begin
          if (ack_i) begin
            fsm    <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
            seed_fix_q <= 1'b0;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign state_o = lfsr;

`ifndef LFSR_ZERO_GUARD_EN
  logic unused_ok;
  assign unused_ok = seed_zero;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Randomized scoreboard bench for lfsr_seq_ctrl: a driver issues operations and pushes the
// expected result, a monitor pops and compares when done_o rises.
module tb_lfsr_seq_ctrl;
  localparam int          WIDTH = 8;
  localparam int          CNT_W = 8;
  localparam logic [7:0]  TAPS  = 8'hB8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [WIDTH-1:0] seed_i;
  logic [CNT_W-1:0] steps_i;
  logic             busy_o;
  logic             load_sel_o;
  logic             shift_en_o;
  logic [WIDTH-1:0] state_o;
  logic             done_o;
  logic             ack_i;
`ifdef LFSR_ZERO_GUARD_EN
  logic             seed_fix_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic             exp_fix_q[$];

  lfsr_seq_ctrl #(.WIDTH(WIDTH), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .seed_i     (seed_i),
    .steps_i    (steps_i),
    .busy_o     (busy_o),
    .load_sel_o (load_sel_o),
    .shift_en_o (shift_en_o),
    .state_o    (state_o),
    .done_o     (done_o),
`ifdef LFSR_ZERO_GUARD_EN
    .seed_fix_o (seed_fix_o),
`endif
    .ack_i      (ack_i)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: run the shift rule steps times with integer arithmetic.
  function automatic logic [WIDTH-1:0] model_run(input logic [WIDTH-1:0] seed, input int steps);
    int s;
    int fb;
    s = int'(seed);
`ifdef LFSR_ZERO_GUARD_EN
    if (s == 0) s = 1;
`endif
    for (int i = 0; i < steps; i++) begin
      fb = $countones(s & int'(TAPS)) % 2;
      s  = ((s * 2) + fb) % (1 << WIDTH);
    end
    return WIDTH'(s);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_fix_q.delete();
  endtask

  task automatic start_op(input logic [WIDTH-1:0] seed, input logic [CNT_W-1:0] steps);
    int n = 0;
    @(negedge clk);
    while ((busy_o || done_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("wait_idle_timeout", 1, 0);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    seed_i  = seed;
    steps_i = steps;
    exp_q.push_back(model_run(seed, int'(steps)));
    exp_cyc_q.push_back(1 + int'(steps));
    exp_fix_q.push_back(seed == '0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    seed_i  = WIDTH'($urandom);
    steps_i = CNT_W'($urandom);
  endtask

  task automatic finish_op(input int max_cyc, input int ack_delay, input bit start_with_ack);
    int  n   = 0;
    bit  got = 1'b0;
    while (n < max_cyc && !got) begin
      @(posedge clk);
      #1;
      if (done_o) got = 1'b1;
      else begin
        ack_i = 1'($urandom_range(0, 1));
        n++;
      end
    end
    ack_i = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      apply_reset();
    end else begin
      for (int k = 0; k < ack_delay; k++) begin
        start_i = 1'($urandom_range(0, 1));
        seed_i  = WIDTH'($urandom);
        steps_i = CNT_W'($urandom);
        @(posedge clk);
        #1;
      end
      ack_i   = 1'b1;
      start_i = start_with_ack;
      @(posedge clk);
      #1;
      ack_i   = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      check("after_ack_busy", busy_o, 0);
      check("after_ack_done", done_o, 0);
    end
  endtask

  // monitor / scoreboard
  int               busy_cyc  = 0;
  int               shift_cyc = 0;
  int               load_cyc  = 0;
  bit               in_done   = 1'b0;
  logic [WIDTH-1:0] held;

  always @(negedge clk) begin
    if (!rst && !busy_o) begin
      busy_cyc  = 0;
      shift_cyc = 0;
      load_cyc  = 0;
      in_done   = 1'b0;
      check("idle_done", done_o, 0);
      check("idle_shift_en", shift_en_o, 0);
      check("idle_load_sel", load_sel_o, 0);
`ifdef LFSR_ZERO_GUARD_EN
      check("idle_seed_fix", seed_fix_o, 0);
`endif
    end else if (!rst && !done_o) begin
      busy_cyc++;
      if (shift_en_o) shift_cyc++;
      if (load_sel_o) load_cyc++;
    end else if (!rst) begin
      check("done_shift_en", shift_en_o, 0);
      check("done_busy", busy_o, 1);
      if (!in_done) begin
        in_done = 1'b1;
        held    = state_o;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("result_state", state_o, exp_q.pop_front());
          check("busy_cycles", busy_cyc, exp_cyc_q[0]);
          check("shift_cycles", shift_cyc, exp_cyc_q.pop_front());
          check("load_cycles", load_cyc, 1);
`ifdef LFSR_ZERO_GUARD_EN
          check("seed_fix", seed_fix_o, exp_fix_q.pop_front());
`else
          void'(exp_fix_q.pop_front());
`endif
        end
      end else begin
        check("done_state_stable", state_o, held);
      end
    end
  end

  // stimulus
  initial begin
    start_i = 1'b0;
    ack_i   = 1'b0;
    seed_i  = '0;
    steps_i = '0;
    apply_reset();
    @(negedge clk);
    check("reset_state", state_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);

    // basic run: 01 -> 02 04 08 11 23
    start_op(8'h01, 8'd5);
    finish_op(30, 2, 1'b0);
    check("known_result_01x5", model_run(8'h01, 5), 8'h23);

    // zero steps: LOAD then straight to DONE
    start_op(8'hA5, 8'd0);
    finish_op(10, 0, 1'b0);

    // long hold in DONE with start pulses, then ack with start in the same cycle
    start_op(8'h3C, 8'd4);
    finish_op(30, 10, 1'b1);
    start_op(8'h5A, 8'd3);
    finish_op(30, 1, 1'b0);

    // reset aborts a long run
    start_op(8'h01, 8'd200);
    repeat (51) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_fix_q.delete();
    @(negedge clk);
    check("abort_state", state_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_shift_en", shift_en_o, 0);
    check("abort_load_sel", load_sel_o, 0);
    rst = 1'b0;
    start_op(8'h01, 8'd5);
    finish_op(30, 0, 1'b0);

    // zero seed
    start_op(8'h00, 8'd3);
    finish_op(30, 1, 1'b0);

    // maximum step count
    start_op(8'h01, 8'hFF);
    finish_op(300, 0, 1'b0);

    // randomized operations
    for (int t = 0; t < 20; t++) begin
      logic [CNT_W-1:0] st;
      st = CNT_W'($urandom_range(0, 24));
      start_op(WIDTH'($urandom), st);
      finish_op(int'(st) + 20, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer for the seed-load/shift LFSR datapath used by the associative-memory address generator. It drives the per-bit 2:1 mux select (seed vs. feedback) and the shift enable, and owns the WIDTH-bit LFSR state register. It accepts a start request carrying a seed and a step count, runs the LFSR for exactly that many shifts, then presents the result with a valid/ack handshake.

Parameters:
WIDTH, 8, LFSR width in bits (>=2)
TAPS, 8'hB8, feedback tap mask; bit i set means state[i] is XORed into the feedback
CNT_W, 8, width of the step counter and of steps_i

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start_i  input  1  start request; sampled only in IDLE
seed_i  input  WIDTH  seed value, captured with start_i
steps_i  input  CNT_W  number of shifts to run, captured with start_i
busy_o  output  1  high in LOAD, RUN and DONE
load_sel_o  output  1  mux select S to the datapath: 1 = seed (I1), 0 = feedback (I0)
shift_en_o  output  1  LFSR register enable
state_o  output  WIDTH  current LFSR state
done_o  output  1  result valid; held until ack_i
ack_i  input  1  result accepted; sampled only in DONE

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset: FSM goes to IDLE. state_o, the step counter, busy_o, load_sel_o, shift_en_o and done_o all go to 0. Reset has priority over every other input and aborts any operation in progress.
- Feedback: next = {state[WIDTH-2:0], ^(state & TAPS)} (Fibonacci form, shift left, feedback enters bit 0).
- FSM: Moore outputs, decoded from the registered state.
- IDLE: all outputs 0 except state_o, which holds its last value. If start_i=1 at an edge, capture seed_i into a seed register and steps_i into the counter, then go to LOAD.
- LOAD (exactly 1 cycle): load_sel_o=1, shift_en_o=1. At the edge ending this cycle, state <= seed. Then go to DONE if the captured steps is 0, otherwise go to RUN.
- RUN: load_sel_o=0, shift_en_o=1. On each edge, state <= next and the counter decrements. When the counter is 1 at an edge, go to DONE. RUN therefore lasts exactly steps cycles.
- DONE: done_o=1, shift_en_o=0, and state_o is frozen. If ack_i=1 at an edge, go to IDLE. done_o stays high indefinitely until ack_i arrives.
- Latency: start_i is sampled at edge E0. LOAD occupies E0..E1, and done_o rises after edge E(1+steps).
- start_i outside IDLE is ignored, including in the same cycle as the ack. No queueing is performed.
- ack_i outside DONE is ignored.
- seed_i and steps_i only need to be valid in the start cycle.
- Maximum steps is 2^CNT_W-1. The counter never wraps.

Optional Feature:
LFSR_ZERO_GUARD_EN
- Defined: if the captured seed is all-zero, LOAD loads 1 instead, which avoids the all-zero lockup state. An extra output port seed_fix_o (1 bit) goes high in DONE for that operation and clears in IDLE and on reset.
- Not defined: a zero seed is loaded as-is, the state stays 0 for all shifts, and the seed_fix_o port does not exist.

Test Plan:
1. Reset, then start with seed=8'h01, steps=5 -> states 02, 04, 08, 11, 23 during RUN; done_o rises 6 edges after start; state_o=8'h23; busy_o=1 throughout.
2. Seed=8'hA5, steps=0 -> LOAD then DONE; done_o rises 1 edge after start with state_o=8'hA5; shift_en_o high only in LOAD.
3. In DONE, hold ack_i=0 for 10 cycles while pulsing start_i -> done_o and state_o stable, start ignored. Then ack_i=1 together with start_i=1 -> IDLE with start ignored; a new start next cycle is accepted.
4. Seed=8'h01, steps=200, assert rst at RUN cycle 50 -> next cycle all outputs 0 and state_o=0; a new start then runs normally.
5. Seed=8'h00, steps=3 -> with LFSR_ZERO_GUARD_EN: states 02, 04, 08, final state 08, seed_fix_o=1. Without it: final state 00.
6. steps=8'hFF, seed=8'h01 -> exactly 255 shift_en_o cycles in RUN; the result matches the reference model; the counter does not wrap.
